alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller that drives the registered ALU from the operand/opcode side. It is the producer end of the ALU's A/B/ALUOp interface and the consumer of its C/Zero result.
- Accepts one RV32 instruction per handshake and decodes LUI, AUIPC, ADDI and ADD.
- Reads register operands, sequences the one-cycle-latency ALU, captures the result and presents a writeback beat with a valid/ready handshake.

Parameters:
- DATA_W, 32, datapath width for operands, pc and result.
- OP_W, 5, ALU opcode width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  one clock; reset is synchronous and active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  32  instruction word.
- pc  in  DATA_W  pc of the instruction.
- rs1_addr  out  5  register-file read address 1.
- rs2_addr  out  5  register-file read address 2.
- rs1_data  in  DATA_W  combinational read data for rs1_addr.
- rs2_data  in  DATA_W  combinational read data for rs2_addr.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  OP_W  nop=0, lui=1, auipc=2, add=3.
- alu_c  in  DATA_W  registered ALU result.
- alu_zero  in  1  ALU zero flag (bit 0 of the ALU Zero output).
- wb_valid  out  1  writeback beat valid.
- wb_ready  in  1  writeback sink accepts the beat.
- wb_we  out  1  register write enable for this beat.
- wb_rd  out  5  destination register.
- wb_data  out  DATA_W  captured ALU result.
- wb_zero  out  1  captured zero flag.
- wb_illegal  out  1  instruction was not decodable.
- retired  out  CNT_W  count of accepted writeback beats.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, all registered outputs 0, alu_op=nop, retired=0.
  - Reset overrides every state, including mid-instruction and while wb_valid is pending; the pending beat is dropped.
- FSM states: IDLE, DECODE, EXEC, WAIT, WB.
- IDLE:
  - instr_ready=1 only in IDLE.
  - On instr_valid at a posedge, latch instr and pc, then go to DECODE.
- DECODE (1 cycle):
  - rs1_addr=instr[19:15], rs2_addr=instr[24:20].
  - Register operands from rs1_data/rs2_data and decoded opcode/immediates, then go to EXEC.
  - Illegal instruction: skip EXEC and WAIT, go to WB with wb_illegal=1 and wb_we=0.
- Decode rules:
  - opcode 0110111 (LUI): op=lui, A=0, B={instr[31:12],12'b0}.
  - opcode 0010111 (AUIPC): op=auipc, A=pc, B={instr[31:12],12'b0}.
  - opcode 0010011 with funct3=000 (ADDI): op=add, A=rs1_data, B=sign-extended instr[31:20].
  - opcode 0110011 with funct3=000 and funct7=0000000 (ADD): op=add, A=rs1_data, B=rs2_data.
  - Anything else is illegal.
- EXEC (1 cycle): drive alu_op with the decoded op and alu_a/alu_b; the ALU samples at the end of this cycle. Then go to WAIT.
- WAIT (1 cycle):
  - alu_op=nop so the ALU holds C; alu_a/alu_b hold their values.
  - At the end of the cycle capture wb_data=alu_c and wb_zero=alu_zero, then go to WB.
- Latency: instruction accept to wb_valid is 4 cycles for legal instructions and 2 cycles for illegal ones.
- alu_op is nonzero only in EXEC.
- WB:
  - wb_valid=1; wb_rd=instr[11:7]; wb_we=1 unless illegal or rd==0.
  - All wb_* outputs hold stable until wb_ready is sampled high.
  - On acceptance: retired increments by 1, with modulo 2^CNT_W wrap; illegal beats also count. Then go to IDLE.
  - No new instruction is accepted in the same cycle as wb acceptance; instr_ready rises the cycle after.
- Arithmetic: all additions are done in the ALU, modulo 2^DATA_W with no overflow flag. The controller only forms operands.
- instr/pc changes while the controller is not in IDLE are ignored.

Test Plan:
- Reset, then LUI x5,0x12345 (instr=0x123452B7) -> alu_op=1 in EXEC, alu_a=0, alu_b=0x12345000; after 4 cycles wb_valid=1, wb_rd=5, wb_data=0x12345000, wb_we=1, wb_zero=0.
- AUIPC x1,0x1 with pc=0x100 (instr=0x00001097) -> alu_op=2, alu_a=0x100, alu_b=0x1000, wb_data=0x1100.
- ADD x3,x1,x2 with rs1_data=0xFFFFFFFF and rs2_data=1 -> wb_data=0, wb_zero=1, wb_we=1; ADDI x4,x0,-1 with rs1_data=0 -> wb_data=0xFFFFFFFF.
- Illegal instr=0xFFFFFFFF -> wb_valid after 2 cycles, wb_illegal=1, wb_we=0; alu_op stays 0 throughout.
- Hold wb_ready=0 for 5 cycles, then set it to 1 -> wb_* outputs stable for all 5 cycles; retired increments once; instr_ready=1 the following cycle. ADDI x0,x0,5 -> wb_we=0.
- Assert rst in EXEC and again in WB with wb_ready=0 -> next cycle state=IDLE, wb_valid=0, alu_op=0, retired=0, instr_ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the registered ALU: decodes LUI/AUIPC/ADDI/ADD,
// forms operands, sequences the ALU and presents a writeback beat.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zero,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              wb_illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_WB
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              ill_q, ill_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [4:0]        rd;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] imm_i;
  logic              is_lui;
  logic              is_auipc;
  logic              is_addi;
  logic              is_add;

  assign opc   = instr_q[6:0];
  assign f3    = instr_q[14:12];
  assign f7    = instr_q[31:25];
  assign rd    = instr_q[11:7];
  assign imm_u = DATA_W'($signed({instr_q[31:12], 12'b0}));
  assign imm_i = DATA_W'($signed(instr_q[31:20]));

  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_addi  = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_add   = (opc == 7'b0110011) && (f3 == 3'b000)
                  && (f7 == 7'b0000000);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ill_d   = ill_q;
    we_d    = we_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          pc_d    = pc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ill_d   = 1'b0;
        state_d = S_EXEC;
        unique case (1'b1)
          is_lui: begin
            op_d = OP_LUI;
            a_d  = '0;
            b_d  = imm_u;
          end
          is_auipc: begin
            op_d = OP_AUIPC;
            a_d  = pc_q;
            b_d  = imm_u;
          end
          is_addi: begin
            op_d = OP_ADD;
            a_d  = rs1_data;
            b_d  = imm_i;
          end
          is_add: begin
            op_d = OP_ADD;
            a_d  = rs1_data;
            b_d  = rs2_data;
          end
          default: begin
            op_d    = OP_NOP;
            a_d     = '0;
            b_d     = '0;
            ill_d   = 1'b1;
            data_d  = '0;
            zero_d  = 1'b0;
            state_d = S_WB;
          end
        endcase
        we_d = ~ill_d && (rd != 5'd0);
      end
      S_EXEC: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        data_d  = alu_c;
        zero_d  = alu_zero;
        state_d = S_WB;
      end
      S_WB: begin
        if (wb_ready) begin
          ret_d   = ret_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOP;
      ill_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      we_q    <= we_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ret_q   <= ret_d;
    end
  end

  // the ALU only sees a real opcode in EXEC so it holds C otherwise
  assign alu_op      = (state_q == S_EXEC) ? op_q : OP_NOP;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rs1_addr    = instr_q[19:15];
  assign rs2_addr    = instr_q[24:20];
  assign instr_ready = (state_q == S_IDLE);
  assign wb_valid    = (state_q == S_WB);
  assign wb_we       = we_q;
  assign wb_rd       = rd;
  assign wb_data     = data_q;
  assign wb_zero     = zero_q;
  assign wb_illegal  = ill_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a registered ALU
// and a small register file model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        wb_illegal;
  logic [31:0] retired;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk),
    .rst(rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .pc(pc),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_c(alu_c),
    .alu_zero(alu_zero),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_we(wb_we),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .wb_zero(wb_zero),
    .wb_illegal(wb_illegal),
    .retired(retired)
  );

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  // registered ALU: nop holds C
  logic [31:0] c_q;
  always @(posedge clk) begin
    case (alu_op)
      5'd1: c_q <= alu_b;
      5'd2: c_q <= alu_a + alu_b;
      5'd3: c_q <= alu_a + alu_b;
      default: c_q <= c_q;
    endcase
  end
  assign alu_c    = c_q;
  assign alu_zero = (c_q == 32'd0);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero;
    logic        we;
    logic        ill;
    logic        cdata;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_ret;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(mon_e.rd));
        chk("wb_we", 64'(wb_we), 64'(mon_e.we));
        chk("wb_illegal", 64'(wb_illegal), 64'(mon_e.ill));
        if (mon_e.cdata) begin
          chk("wb_data", 64'(wb_data), 64'(mon_e.data));
          chk("wb_zero", 64'(wb_zero), 64'(mon_e.zero));
        end
      end
    end
  end

  task automatic accept(input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    chk("instr_ready_idle", 64'(instr_ready), 64'd1);
    instr       = ins;
    pc          = p;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0041_01B3;
    pc          = 32'hBAD0_0000;
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] p,
                     input exp_t e, input int lat,
                     input logic [4:0] eop, input logic [31:0] ea,
                     input logic [31:0] eb, input int hold);
    int          n;
    int          nops;
    logic [4:0]  gop;
    logic [31:0] ga;
    logic [31:0] gb;
    logic [39:0] snap;
    sb.push_back(e);
    accept(ins, p);
    n    = 1;
    nops = 0;
    gop  = '0;
    ga   = '0;
    gb   = '0;
    while (!wb_valid && n < 16) begin
      if (alu_op != 5'd0) begin
        nops++;
        gop = alu_op;
        ga  = alu_a;
        gb  = alu_b;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("alu_op_cycles", 64'(nops), (eop != 5'd0) ? 64'd1 : 64'd0);
    if (eop != 5'd0) begin
      chk("alu_op", 64'(gop), 64'(eop));
      chk("alu_a", 64'(ga), 64'(ea));
      chk("alu_b", 64'(gb), 64'(eb));
    end
    snap = {wb_rd, wb_we, wb_data, wb_zero, wb_illegal};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(wb_valid), 64'd1);
      chk("hold_stable",
          64'({wb_rd, wb_we, wb_data, wb_zero, wb_illegal}),
          64'(snap));
      chk("hold_ready_low", 64'(instr_ready), 64'd0);
    end
    chk("retired_pre", 64'(retired), 64'(exp_ret));
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    exp_ret  = exp_ret + 32'd1;
    chk("retired", 64'(retired), 64'(exp_ret));
    chk("wb_valid_drop", 64'(wb_valid), 64'd0);
    chk("instr_ready_after", 64'(instr_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_instr_ready"}, 64'(instr_ready), 64'd1);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_retired"}, 64'(retired), 64'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_ret = 32'd0;
  endtask

  function automatic exp_t mk(input logic [4:0] rd,
                              input logic [31:0] d,
                              input logic z, input logic we,
                              input logic ill, input logic cd);
    exp_t e;
    e.rd    = rd;
    e.data  = d;
    e.zero  = z;
    e.we    = we;
    e.ill   = ill;
    e.cdata = cd;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0000 + 32'(i);
    rf[0]       = 32'd0;
    rf[1]       = 32'hFFFF_FFFF;
    rf[2]       = 32'd1;
    c_q         = 32'h5555_5555;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    pc          = 32'd0;
    wb_ready    = 1'b0;
    exp_ret     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    chk("reset_alu_a", 64'(alu_a), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);

    // LUI x5,0x12345
    run(32'h1234_52B7, 32'h0, mk(5'd5, 32'h1234_5000, 0, 1, 0, 1),
        4, 5'd1, 32'h0, 32'h1234_5000, 0);
    // AUIPC x1,0x1 at pc 0x100
    run(32'h0000_1097, 32'h100, mk(5'd1, 32'h1100, 0, 1, 0, 1),
        4, 5'd2, 32'h100, 32'h1000, 0);
    // ADD x3,x1,x2
    run(32'h0020_81B3, 32'h104, mk(5'd3, 32'h0, 1, 1, 0, 1),
        4, 5'd3, 32'hFFFF_FFFF, 32'h1, 0);
    // ADDI x4,x0,-1
    run(32'hFFF0_0213, 32'h108, mk(5'd4, 32'hFFFF_FFFF, 0, 1, 0, 1),
        4, 5'd3, 32'h0, 32'hFFFF_FFFF, 0);
    // illegal word
    run(32'hFFFF_FFFF, 32'h10C, mk(5'd31, 32'h0, 0, 0, 1, 0),
        2, 5'd0, 32'h0, 32'h0, 0);
    // ADDI x0,x0,5 held off by the sink
    run(32'h0050_0013, 32'h110, mk(5'd0, 32'h5, 0, 0, 0, 1),
        4, 5'd3, 32'h0, 32'h5, 5);

    // reset while in EXEC
    accept(32'h0020_81B3, 32'h200);
    @(posedge clk);
    #1;
    chk("rst_exec_in_exec", 64'(alu_op), 64'd3);
    pulse_rst();
    check_reset_state("rst_exec");

    run(32'h0020_81B3, 32'h204, mk(5'd3, 32'h0, 1, 1, 0, 1),
        4, 5'd3, 32'hFFFF_FFFF, 32'h1, 1);

    // reset while a beat is pending
    accept(32'h1234_52B7, 32'h300);
    n = 1;
    while (!wb_valid && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_wb_reached", 64'(wb_valid), 64'd1);
    pulse_rst();
    check_reset_state("rst_wb");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
